// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter family: FSM encoding, default widths
// and the shift-then-saturate output stage.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } fir_state_t;

    localparam int FIR_DATA_IN_WIDTH  = 16;
    localparam int FIR_TAP_WIDTH      = 24;
    localparam int FIR_TAP_COUNT      = 108;
    localparam int FIR_DATA_OUT_WIDTH = 32;

    // Working width for sat_shift; callers sign-extend into it and truncate the result.
    localparam int SAT_MAXW = 128;

    function automatic logic signed [SAT_MAXW-1:0] sat_shift(
        input logic signed [SAT_MAXW-1:0] acc,
        input int                         shift,
        input int                         out_w
    );
        logic signed [SAT_MAXW-1:0] shifted;
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        shifted = acc >>> shift;
        hi      = ({{(SAT_MAXW-1){1'b0}}, 1'b1} << (out_w - 1)) - {{(SAT_MAXW-1){1'b0}}, 1'b1};
        lo      = ~hi;
        if (shifted > hi)
            return hi;
        else if (shifted < lo)
            return lo;
        else
            return shifted;
    endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Circular sample history: one write per accepted sample, asynchronous read
// at an arbitrary index, synchronous clear that also rewinds the write pointer.
module fir_hist_ram #(
    parameter int DEPTH = 108,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       we,
    input  logic signed [WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic signed [WIDTH-1:0]    rdata,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic signed [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            // A sample arriving with the clear lands in slot 0 of the emptied history.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            if (we) begin
                mem[0] <= wdata;
                wr_ptr <= AW'(1);
            end else begin
                wr_ptr <= '0;
            end
        end else if (we) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fir_folded_mac.sv
// Folded FIR: one multiplier and accumulator swept over all taps per sample,
// with valid/ready handshakes, writable coefficients and saturated output.
//
//   state  | meaning
//   IDLE   | ready for a sample; coefficient writes and clear honoured
//   ACCUM  | one tap per cycle, TAP_COUNT cycles
//   DRAIN  | fold the last product in, register the saturated result
//   OUTPUT | hold result until out_ready
module fir_folded_mac
    import fir_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = FIR_DATA_IN_WIDTH,
    parameter int TAP_WIDTH      = FIR_TAP_WIDTH,
    parameter int TAP_COUNT      = FIR_TAP_COUNT,
    parameter int DATA_OUT_WIDTH = FIR_DATA_OUT_WIDTH,
    parameter int OUT_SHIFT      = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]   data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_OUT_WIDTH-1:0]  data_out,
    input  logic                              coef_we,
    input  logic [$clog2(TAP_COUNT)-1:0]      coef_addr,
    input  logic signed [TAP_WIDTH-1:0]       coef_data,
    output logic                              busy
);

    localparam int ACC_WIDTH = DATA_IN_WIDTH + TAP_WIDTH + $clog2(TAP_COUNT);
    localparam int PW        = DATA_IN_WIDTH + TAP_WIDTH;
    localparam int AW        = $clog2(TAP_COUNT);
    localparam logic [AW-1:0] LAST = AW'(TAP_COUNT - 1);

    fir_state_t state, state_nx;

    logic [AW-1:0]                tap_cnt;
    logic [AW-1:0]                coef_idx;
    logic [AW-1:0]                rd_idx;
    logic [AW-1:0]                wr_ptr;
    logic signed [TAP_WIDTH-1:0]  coef_mem [TAP_COUNT];
    logic signed [DATA_IN_WIDTH-1:0] hist_rd;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  final_sum;
    logic                         accept;
    logic                         hist_clear;

    assign accept     = (state == IDLE) && in_valid;
    assign hist_clear = (state == IDLE) && clear;
    assign coef_idx   = LAST - tap_cnt;
    assign final_sum  = acc + ACC_WIDTH'(prod);

    fir_hist_ram #(
        .DEPTH (TAP_COUNT),
        .WIDTH (DATA_IN_WIDTH)
    ) u_hist (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (hist_clear),
        .we     (accept),
        .wdata  (data_in),
        .rd_idx (rd_idx),
        .rdata  (hist_rd),
        .wr_ptr (wr_ptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)          state_nx = ACCUM;
            ACCUM:   if (tap_cnt == '0)   state_nx = DRAIN;
            DRAIN:                        state_nx = OUTPUT;
            OUTPUT:  if (out_ready)       state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            OUTPUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // tap_cnt counts down to the terminal tap; the product lags the read by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAP_COUNT; i++) coef_mem[i] <= '0;
            tap_cnt  <= '0;
            rd_idx   <= '0;
            prod     <= '0;
            acc      <= '0;
            data_out <= '0;
        end else begin
            if ((state == IDLE) && coef_we && (int'(coef_addr) < TAP_COUNT))
                coef_mem[coef_addr] <= coef_data;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= '0;
                        prod    <= '0;
                        tap_cnt <= LAST;
                        rd_idx  <= hist_clear ? '0 : wr_ptr;
                    end
                end
                ACCUM: begin
                    prod    <= PW'(hist_rd) * PW'(coef_mem[coef_idx]);
                    acc     <= acc + ACC_WIDTH'(prod);
                    tap_cnt <= tap_cnt - AW'(1);
                    rd_idx  <= (rd_idx == '0) ? LAST : rd_idx - AW'(1);
                end
                DRAIN: begin
                    data_out <= DATA_OUT_WIDTH'(sat_shift(SAT_MAXW'(final_sum), OUT_SHIFT, DATA_OUT_WIDTH));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_folded_mac.sv
// Bench for fir_folded_mac: two 4-tap instances share all inputs and differ in
// output width/shift; results are checked against a sum-of-products model.
module tb_fir_folded_mac;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] data_in = '0;
    logic out_ready = 1'b0;
    logic coef_we = 1'b0;
    logic [1:0] coef_addr = '0;
    logic signed [23:0] coef_data = '0;

    logic in_ready_a, out_valid_a, busy_a;
    logic in_ready_b, out_valid_b, busy_b;
    logic signed [15:0] data_out_a;
    logic signed [19:0] data_out_b;

    int checks = 0;
    int errors = 0;

    longint hist_m [T];
    longint coef_m [T];
    int     wr_m;
    longint exp_a, exp_b;

    always #5 clk = ~clk;

    fir_folded_mac #(.DATA_IN_WIDTH(16), .TAP_WIDTH(24), .TAP_COUNT(T),
                     .DATA_OUT_WIDTH(16), .OUT_SHIFT(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_a), .data_in(data_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .data_out(data_out_a), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_a));

    fir_folded_mac #(.DATA_IN_WIDTH(16), .TAP_WIDTH(24), .TAP_COUNT(T),
                     .DATA_OUT_WIDTH(20), .OUT_SHIFT(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_b), .data_in(data_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .data_out(data_out_b), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_b));

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int sh, input int w);
        longint s, hi, lo;
        s  = v >>> sh;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic longint rnd_s(input int w);
        longint v;
        v = longint'($urandom) & ((64'sd1 <<< w) - 1);
        if (v >= (64'sd1 <<< (w - 1))) v -= (64'sd1 <<< w);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < T; i++) begin
            hist_m[i] = 0;
            coef_m[i] = 0;
        end
        wr_m = 0;
    endtask

    task automatic model_accept(input longint x, input bit clr, input bit cw,
                                input int ca, input longint cd);
        longint y;
        int newest;
        if (cw) coef_m[ca] = cd;
        if (clr) begin
            for (int i = 0; i < T; i++) hist_m[i] = 0;
            wr_m = 0;
        end
        hist_m[wr_m] = x;
        newest = wr_m;
        wr_m = (wr_m + 1) % T;
        y = 0;
        for (int k = 0; k < T; k++) y += hist_m[(newest - k + T) % T] * coef_m[k];
        exp_a = sat(y, 0, 16);
        exp_b = sat(y, 2, 20);
    endtask

    task automatic write_coef(input int a, input longint d);
        coef_we = 1'b1; coef_addr = 2'(a); coef_data = 24'(d);
        @(posedge clk); #1;
        coef_we = 1'b0;
        coef_m[a] = d;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < T; i++) hist_m[i] = 0;
        wr_m = 0;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
    task automatic run_sample(input longint x, input bit clr, input bit cw, input int ca,
                              input longint cd, input int hold, input bit spam);
        int cyc;
        in_valid = 1'b1; data_in = 16'(x); clear = clr;
        coef_we = cw; coef_addr = 2'(ca); coef_data = 24'(cd);
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
        model_accept(x, clr, cw, ca, cd);
        chk("busy", busy_a, 1);
        chk("in_ready_busy", in_ready_a, 0);
        cyc = 0;
        while (!out_valid_a && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, T + 1);
        chk("data_a", data_out_a, exp_a);
        chk("data_b", data_out_b, exp_b);
        chk("valid_b", out_valid_b, 1);
        if (spam) begin
            in_valid = 1'b1; data_in = 16'sd1234;
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 24'sd99;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid_a, 1);
            chk("hold_data", data_out_a, exp_a);
            chk("hold_in_ready", in_ready_a, 0);
        end
        in_valid = 1'b0; coef_we = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid_a, 0);
        chk("release_in_ready", in_ready_a, 1);
        chk("data_keep", data_out_a, exp_a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready_a, 1);
        chk({tag, "_out_valid"}, out_valid_a, 0);
        chk({tag, "_data_a"}, data_out_a, 0);
        chk({tag, "_data_b"}, data_out_b, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_busy_b"}, busy_b, 0);
    endtask

    initial begin
        int imp [5];
        imp = '{1, 2, 3, 4, 0};
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // impulse response
        for (int i = 0; i < T; i++) write_coef(i, i + 1);
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
            chk($sformatf("impulse_%0d", i), data_out_a, imp[i]);
        end

        // saturation both ways
        for (int i = 0; i < T; i++) write_coef(i, 32767);
        for (int i = 0; i < T; i++) run_sample(32767, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("sat_pos", data_out_a, 32767);
        for (int i = 0; i < T; i++) run_sample(-32768, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("sat_neg", data_out_a, -32768);

        // arithmetic shift floors toward minus infinity
        write_coef(0, 1);
        for (int i = 1; i < T; i++) write_coef(i, 0);
        run_sample(-7, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("shift_b", data_out_b, -2);
        chk("shift_a", data_out_a, -7);

        // hold with ignored in_valid and coef_we, then prove coef[0] is still 1
        run_sample(5, 1'b0, 1'b0, 0, 0, 6, 1'b1);
        run_sample(1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("coef_unchanged", data_out_a, 1);

        // clear
        for (int i = 0; i < T; i++) write_coef(i, 1);
        clear_pulse();
        run_sample(5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_sample(5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        clear_pulse();
        run_sample(3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("clear_pulse", data_out_a, 3);
        run_sample(5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_sample(5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_sample(3, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("clear_with_valid", data_out_a, 3);

        // coefficient write on the accept edge is used by that sample
        run_sample(2, 1'b1, 1'b1, 0, 7, 0, 1'b0);
        chk("coef_same_edge", data_out_a, 14);

        // reset in the middle of ACCUM
        in_valid = 1'b1; data_in = 16'sd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_accum_busy", busy_a, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_stale_valid", out_valid_a, 0);
        end
        for (int i = 0; i < T; i++) write_coef(i, i + 1);
        run_sample(1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("post_reset", data_out_a, 1);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            longint x, cd;
            bit clr, cw;
            int ca;
            if ($urandom_range(0, 4) == 0)
                write_coef($urandom_range(0, T - 1),
                           ($urandom_range(0, 1) == 0) ? rnd_s(5) : rnd_s(24));
            x   = ($urandom_range(0, 1) == 0) ? rnd_s(6) : rnd_s(16);
            clr = ($urandom_range(0, 7) == 0);
            cw  = ($urandom_range(0, 3) == 0);
            ca  = $urandom_range(0, T - 1);
            cd  = ($urandom_range(0, 1) == 0) ? rnd_s(5) : rnd_s(24);
            run_sample(x, clr, cw, ca, cd, $urandom_range(0, 2), 1'(($urandom_range(0, 3) == 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
